// File: rtl/wb_soc_ascii2int.sv
// wb_soc_ascii2int
// Streaming ASCII-decimal to unsigned binary converter for the debug/boot
// console. Takes one byte per cycle, accumulates decimal digits and, on a
// terminator (CR, LF, space, comma), presents the value plus status flags
// until the consumer accepts it.
//
// Ports:
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   in_data/in_valid    ASCII byte stream, accepted when in_valid && in_ready
//   in_ready            low only while a result is pending (and in reset)
//   out_value           parsed value (0 on error, all-ones on overflow)
//   out_digits          digit characters consumed, saturating counter
//   out_overflow        value exceeded 2^WIDTH-1
//   out_error           a non-digit, non-terminator character was seen
//   out_valid/out_ready result handshake; result held until accepted
module wb_soc_ascii2int #(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_value,
    output logic [DIGIT_W-1:0] out_digits,
    output logic               out_overflow,
    output logic               out_error,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, SKIP, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [DIGIT_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               latch;

    logic               hs;
    logic               is_digit;
    logic               is_term;
    logic [3:0]         dval;
    logic [WIDTH+3:0]   mac;
    logic               mac_ovf;
    logic [DIGIT_W-1:0] cnt_inc;

    localparam logic [DIGIT_W-1:0] CNT_ONE = {{(DIGIT_W-1){1'b0}}, 1'b1};

    assign hs       = in_valid & in_ready;
    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_term  = (in_data == 8'h0D) || (in_data == 8'h0A) ||
                      (in_data == 8'h20) || (in_data == 8'h2C);
    assign dval     = in_data[3:0];

    // acc*10 + d without a multiplier; the 4 extra bits catch any carry
    // past WIDTH (max acc*10+9 < 16*2^WIDTH).
    assign mac     = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1) +
                     {{WIDTH{1'b0}}, dval};
    assign mac_ovf = ovf_q | (|mac[WIDTH+3:WIDTH]);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            out_value    <= '0;
            out_digits   <= '0;
            out_overflow <= 1'b0;
            out_error    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            if (latch) begin
                // Error wins over overflow and forces the value to zero.
                out_value    <= err_q ? '0 : acc_q;
                out_digits   <= cnt_q;
                out_overflow <= ovf_q & ~err_q;
                out_error    <= err_q;
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (is_digit) begin
                        acc_d   = {{(WIDTH-4){1'b0}}, dval};
                        cnt_d   = CNT_ONE;
                        state_d = ACCUM;
                    end else if (!is_term) begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                    // leading / repeated separators are simply dropped
                end
            end
            ACCUM: begin
                if (hs) begin
                    if (is_digit) begin
                        acc_d = mac_ovf ? '1 : mac[WIDTH-1:0];
                        ovf_d = mac_ovf;
                        cnt_d = cnt_inc;
                    end else if (is_term) begin
                        latch   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
            end
            SKIP: begin
                if (hs && is_term) begin
                    latch   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs, decoded from the state register only
    always_comb begin
        in_ready  = rst_n && (state_q != DONE);
        out_valid = (state_q == DONE);
    end

endmodule

// File: tb/tb_wb_soc_ascii2int.sv
module tb_wb_soc_ascii2int;
    localparam int WIDTH   = 32;
    localparam int DIGIT_W = 5;
    localparam longint unsigned VMAX = (64'd1 << WIDTH) - 1;
    localparam int CMAX = (1 << DIGIT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         in_data = 8'h00;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   out_value;
    logic [DIGIT_W-1:0] out_digits;
    logic               out_overflow;
    logic               out_error;
    logic               out_valid;
    logic               out_ready = 1'b0;

    wb_soc_ascii2int #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_value(out_value), .out_digits(out_digits),
        .out_overflow(out_overflow), .out_error(out_error),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0]   val;
        logic [DIGIT_W-1:0] dig;
        logic               ovf;
        logic               err;
    } res_t;

    res_t exp_q[$];
    res_t last;
    int   checks = 0;
    int   errors = 0;
    int   nres   = 0;
    int   stalls = 0;
    bit   rand_rdy = 1'b0;

    // Reference model: parser state as plain integers
    int              mst;   // 0 between numbers, 1 in number, 2 discarding
    longint unsigned mval;
    int              mcnt;
    bit              movf, merr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic bit c_digit(input logic [7:0] b);
        return (b >= "0") && (b <= "9");
    endfunction

    function automatic bit c_term(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A) || (b == " ") || (b == ",");
    endfunction

    task automatic model_reset();
        mst = 0; mval = 0; mcnt = 0; movf = 0; merr = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        res_t r;
        if (mst == 0) begin
            if (c_digit(b)) begin
                mval = longint'(b - 8'd48); mcnt = 1; mst = 1;
            end else if (!c_term(b)) begin
                merr = 1; mst = 2;
            end
        end else if (c_term(b)) begin
            r.val = merr ? '0 : mval[WIDTH-1:0];
            r.dig = mcnt[DIGIT_W-1:0];
            r.ovf = movf && !merr;
            r.err = merr;
            exp_q.push_back(r);
            model_reset();
        end else if (mst == 1) begin
            if (c_digit(b)) begin
                mval = mval * 10 + longint'(b - 8'd48);
                if (movf || mval > VMAX) begin
                    movf = 1; mval = VMAX;
                end
                mcnt = (mcnt < CMAX) ? mcnt + 1 : CMAX;
            end else begin
                merr = 1; mst = 2;
            end
        end
    endtask

    // Scoreboard monitor: compare whenever a result is handed over
    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got value %0h, expected no result", out_value);
            end else begin
                e = exp_q.pop_front();
                chk("sb_value",    64'(out_value),    64'(e.val));
                chk("sb_digits",   64'(out_digits),   64'(e.dig));
                chk("sb_overflow", 64'(out_overflow), 64'(e.ovf));
                chk("sb_error",    64'(out_error),    64'(e.err));
            end
            last = '{out_value, out_digits, out_overflow, out_error};
            nres++;
        end
    end

    // Random consumer back-pressure
    always @(posedge clk) begin
        #2;
        if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
            stalls++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready got 0, expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_byte(b);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_last(input string n, input logic [63:0] v, input int d, input bit o, input bit e);
        chk({n, "_value"},    64'(last.val), v);
        chk({n, "_digits"},   64'(last.dig), 64'(d));
        chk({n, "_overflow"}, 64'(last.ovf), 64'(o));
        chk({n, "_error"},    64'(last.err), 64'(e));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [7:0] b;
        model_reset();
        last = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),     64'd0);
        chk("rst_out_valid", 64'(out_valid),    64'd0);
        chk("rst_value",     64'(out_value),    64'd0);
        chk("rst_digits",    64'(out_digits),   64'd0);
        chk("rst_overflow",  64'(out_overflow), 64'd0);
        chk("rst_error",     64'(out_error),    64'd0);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        // basic parse + latency
        send_str("123");
        send_byte(8'h0D);
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        drain();
        chk_last("basic", 64'd123, 3, 0, 0);

        // range edges
        send_str("4294967295\n");
        drain();
        chk_last("max", 64'hFFFF_FFFF, 10, 0, 0);
        send_str("4294967296\n");
        drain();
        chk_last("ovf", 64'hFFFF_FFFF, 10, 1, 0);
        send_str("00000000000000000007,");
        drain();
        chk_last("lead0", 64'd7, 20, 0, 0);

        // error path, never stalled
        stalls = 0;
        send_str("12a4 ");
        chk("err_stalls", 64'(stalls), 64'd0);
        drain();
        chk_last("err", 64'd0, 2, 0, 1);

        // separators
        n0 = nres;
        send_byte(8'h0D);
        send_str("\n 7,,8\n");
        drain();
        chk("sep_count", 64'(nres - n0), 64'd2);
        chk("sep_last", 64'(last.val), 64'd8);

        // back-pressure
        @(posedge clk); #1 out_ready = 1'b0;
        send_str("42\n");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = "9";
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_value",     64'(out_value), 64'd42);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_cycle_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp_next_in_ready", 64'(in_ready), 64'd1);
        chk("bp_accepted", 64'(last.val), 64'd42);
        @(posedge clk);
        model_byte(8'h39);
        #1 in_valid = 1'b0;
        send_str("\n");
        drain();
        chk_last("bp_nine", 64'd9, 1, 0, 0);

        // reset mid-number
        send_str("98");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  64'(in_ready),   64'd0);
        chk("midrst_out_valid", 64'(out_valid),  64'd0);
        chk("midrst_value",     64'(out_value),  64'd0);
        chk("midrst_digits",    64'(out_digits), 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_str("5\n");
        drain();
        chk_last("midrst", 64'd5, 1, 0, 0);

        // randomized traffic with random consumer stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 65) begin
                b = 8'h30 + 8'($urandom_range(0, 9));
            end else if (r < 88) begin
                case ($urandom_range(0, 3))
                    0: b = 8'h0D;
                    1: b = 8'h0A;
                    2: b = 8'h20;
                    default: b = 8'h2C;
                endcase
            end else begin
                do b = 8'($urandom_range(0, 255));
                while (c_digit(b) || c_term(b));
            end
            send_byte(b);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        send_byte(8'h0A);
        rand_rdy = 1'b0;
        @(posedge clk); #3 out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
